// File: rtl/rans_pkg.sv
// rans_pkg
//   Types and constants shared by the rANS multi-stream encoder blocks.
//   sched_state_t  : lane scheduler phase (RUN, DRAIN, FLUSH, WAIT, DONE)
//   DEFAULT_NUM_LANES : lane count used by the scheduler and the
//                       multi-stream wrapper unless overridden
package rans_pkg;

    localparam int DEFAULT_NUM_LANES = 4;

    typedef enum logic [2:0] {
        RUN   = 3'd0,
        DRAIN = 3'd1,
        FLUSH = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } sched_state_t;

endpackage

// File: rtl/rr_pointer.sv
// rr_pointer
//   Round-robin lane pointer. Steps 0,1,..,NUM_LANES-1,0,.. on advance;
//   clear returns it to lane 0 and wins over advance.
// Ports:
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset, pointer -> 0
//   advance : step to the next lane this cycle
//   clear   : return to lane 0 this cycle
//   ptr     : current lane index
module rr_pointer
    import rans_pkg::*;
#(
    parameter int NUM_LANES = DEFAULT_NUM_LANES,
    parameter int PTR_WIDTH = $clog2(NUM_LANES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 advance,
    input  logic                 clear,
    output logic [PTR_WIDTH-1:0] ptr
);

    localparam logic [PTR_WIDTH-1:0] LAST_LANE = PTR_WIDTH'(NUM_LANES - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (clear) begin
            ptr <= '0;
        end else if (advance) begin
            if (ptr == LAST_LANE) begin
                ptr <= '0;
            end else begin
                ptr <= ptr + PTR_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/rans_lane_scheduler.sv
// rans_lane_scheduler
//   Deals one input symbol stream to NUM_LANES encoder lanes in strict
//   round-robin order (the decoder's order). On the block's last symbol it
//   drains the output register, pulses flush to every lane, collects every
//   lane's flush completion and then pulses block_done.
// Ports:
//   clk             : clock, rising edge
//   rst             : synchronous active-high reset
//   s_valid/s_ready : input symbol handshake
//   s_symbol        : input symbol
//   s_last          : accepted symbol closes the block
//   lane_valid      : per-lane valid, one-hot or zero
//   lane_ready      : per-lane ready
//   lane_symbol     : symbol shared by all lanes, qualified by lane_valid
//   lane_flush      : one-cycle flush pulse to all lanes
//   lane_flush_done : per-lane flush completion (pulse or level)
//   block_done      : one-cycle pulse once every lane finished flushing
//   sym_count       : symbols accepted in the current or last block
//
// state | meaning
// ------+---------------------------------------------------------------
// RUN   | accepting symbols; accept with s_last moves to DRAIN
// DRAIN | input closed; wait for the output register to empty
// FLUSH | single cycle, lane_flush all ones, done_seen restarts
// WAIT  | accumulate lane_flush_done until every lane has reported
// DONE  | single cycle, block_done pulse; pointer to lane 0
module rans_lane_scheduler
    import rans_pkg::*;
#(
    parameter int NUM_LANES    = DEFAULT_NUM_LANES,
    parameter int SYMBOL_WIDTH = 8,
    parameter int COUNT_WIDTH  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [SYMBOL_WIDTH-1:0] s_symbol,
    input  logic                    s_last,
    output logic [NUM_LANES-1:0]    lane_valid,
    input  logic [NUM_LANES-1:0]    lane_ready,
    output logic [SYMBOL_WIDTH-1:0] lane_symbol,
    output logic [NUM_LANES-1:0]    lane_flush,
    input  logic [NUM_LANES-1:0]    lane_flush_done,
    output logic                    block_done,
    output logic [COUNT_WIDTH-1:0]  sym_count
);

    localparam int PTR_WIDTH = $clog2(NUM_LANES);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

    sched_state_t state;
    sched_state_t state_next;

    logic                    out_valid;
    logic [SYMBOL_WIDTH-1:0] out_sym;
    logic [PTR_WIDTH-1:0]    out_lane;
    logic [PTR_WIDTH-1:0]    ptr;
    logic [NUM_LANES-1:0]    done_seen;
    logic                    count_clear_pending;

    logic out_lane_ready;
    logic accept;
    logic xfer;
    logic all_done;

    assign out_lane_ready = lane_ready[out_lane];
    assign xfer           = out_valid && out_lane_ready;

    // Gated by rst so nothing is taken while reset is held, even though
    // the registers already look like an idle RUN state.
    assign s_ready = !rst && (state == RUN) && (!out_valid || out_lane_ready);
    assign accept  = s_valid && s_ready;

    // Include this cycle's reports so a final report in WAIT reaches DONE
    // on the very next cycle.
    assign all_done = &(done_seen | lane_flush_done);

    assign lane_symbol = out_sym;

    rr_pointer #(
        .NUM_LANES (NUM_LANES),
        .PTR_WIDTH (PTR_WIDTH)
    ) u_rr_pointer (
        .clk     (clk),
        .rst     (rst),
        .advance (accept),
        .clear   (state == DONE),
        .ptr     (ptr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        lane_flush = '0;
        block_done = 1'b0;
        lane_valid = '0;

        for (int k = 0; k < NUM_LANES; k++) begin
            lane_valid[k] = out_valid && (out_lane == PTR_WIDTH'(k));
        end

        case (state)
            RUN: begin
                if (accept && s_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!out_valid || xfer) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                lane_flush = '1;
                state_next = WAIT;
            end
            WAIT: begin
                if (all_done) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                block_done = 1'b1;
                state_next = RUN;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // Output register: a refill in the same cycle as a drain keeps out_valid
    // high, which is what gives one symbol per cycle with all lanes ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sym   <= '0;
            out_lane  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_sym   <= s_symbol;
            out_lane  <= ptr;
        end else if (xfer) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done_seen <= '0;
        end else if (state == FLUSH) begin
            done_seen <= lane_flush_done;
        end else if (state == WAIT) begin
            done_seen <= done_seen | lane_flush_done;
        end
    end

    // The count of a finished block stays visible until the next block's
    // first symbol is taken, which then restarts it at 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            sym_count           <= '0;
            count_clear_pending <= 1'b0;
        end else if (accept) begin
            count_clear_pending <= 1'b0;
            if (count_clear_pending) begin
                sym_count <= COUNT_WIDTH'(1);
            end else if (sym_count != COUNT_MAX) begin
                sym_count <= sym_count + COUNT_WIDTH'(1);
            end
        end else if (state == DONE) begin
            count_clear_pending <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rans_lane_scheduler.sv
module tb_rans_lane_scheduler;

    localparam int N  = 4;
    localparam int SW = 8;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [SW-1:0] s_symbol;
    logic          s_last;
    logic [N-1:0]  lane_valid;
    logic [N-1:0]  lane_ready;
    logic [SW-1:0] lane_symbol;
    logic [N-1:0]  lane_flush;
    logic [N-1:0]  lane_flush_done;
    logic          block_done;
    logic [CW-1:0] sym_count;

    rans_lane_scheduler #(
        .NUM_LANES    (N),
        .SYMBOL_WIDTH (SW),
        .COUNT_WIDTH  (CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .s_symbol        (s_symbol),
        .s_last          (s_last),
        .lane_valid      (lane_valid),
        .lane_ready      (lane_ready),
        .lane_symbol     (lane_symbol),
        .lane_flush      (lane_flush),
        .lane_flush_done (lane_flush_done),
        .block_done      (block_done),
        .sym_count       (sym_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // reference model
    int            cyc;
    bit            m_run, m_pend, m_pend_last, m_arm, waiting;
    int            m_pend_lane;
    logic [SW-1:0] m_pend_sym;
    int            blk_idx;
    logic [CW-1:0] m_count;
    int            flush_due, flush_cyc, done_due;
    logic [N-1:0]  seen;
    logic [SW-1:0] exp_q [N][$];
    int            blocks_done;

    // observation log
    int recv_cnt [N];
    int last_xfer_cyc, dut_flush_cyc, dut_done_cyc, dut_done_pulses;

    // stimulus control
    int            done_at [N];
    int            dly [N];
    bit            rand_dly, rand_sym;
    logic [N-1:0]  extra_done, rdy_force_lo;
    int            v_pct, r_pct;
    bit            cur_valid, cur_last;
    logic [SW-1:0] cur_sym;
    int            blk_left, sym_seq, accepted_total, blk_start_count;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 1; m_pend = 0; m_pend_last = 0; m_arm = 0; waiting = 0;
        m_pend_lane = 0; m_pend_sym = '0; blk_idx = 0; m_count = '0;
        flush_due = -1; flush_cyc = -1; done_due = -1; seen = '0;
        for (int k = 0; k < N; k++) begin
            exp_q[k].delete();
            done_at[k] = -1;
        end
        cur_valid = 0; cur_last = 0; blk_left = 0; extra_done = '0;
    endtask

    // one clock cycle: drive at negedge, check after settling, update model
    task automatic tick();
        logic [N-1:0] exp_lv, exp_fl;
        logic         exp_rdy;
        bit           acc, xf;
        int           lane;
        if (cyc == flush_due)
            for (int k = 0; k < N; k++)
                done_at[k] = cyc + (rand_dly ? int'($urandom_range(0, 8)) : dly[k]);
        for (int k = 0; k < N; k++) begin
            lane_flush_done[k] = (done_at[k] == cyc) || extra_done[k];
            lane_ready[k] = (int'($urandom_range(0, 99)) < r_pct) && !rdy_force_lo[k];
        end
        if (!cur_valid && blk_left > 0 && int'($urandom_range(0, 99)) < v_pct) begin
            cur_valid = 1;
            cur_sym   = rand_sym ? SW'($urandom) : SW'(sym_seq);
            cur_last  = (blk_left == 1);
        end
        s_valid  = cur_valid;
        s_symbol = cur_sym;
        s_last   = cur_last;
        #1;
        exp_rdy = m_run && (!m_pend || lane_ready[m_pend_lane]);
        exp_lv  = m_pend ? (N'(1) << m_pend_lane) : '0;
        exp_fl  = (cyc == flush_due) ? '1 : '0;
        check("s_ready", s_ready, exp_rdy);
        check("lane_valid", lane_valid, exp_lv);
        if (m_pend) check("lane_symbol", lane_symbol, m_pend_sym);
        check("lane_flush", lane_flush, exp_fl);
        check("block_done", block_done, cyc == done_due);
        check("sym_count", sym_count, m_count);
        for (int k = 0; k < N; k++) begin
            if (lane_valid[k] && lane_ready[k]) begin
                recv_cnt[k]++;
                last_xfer_cyc = cyc;
                if (exp_q[k].size() == 0) check("lane_extra_symbol", exp_q[k].size(), 1);
                else check($sformatf("lane%0d_order", k), lane_symbol, exp_q[k].pop_front());
            end
        end
        if (lane_flush != '0) dut_flush_cyc = cyc;
        if (block_done) begin
            dut_done_cyc = cyc;
            dut_done_pulses++;
        end
        xf  = m_pend && lane_ready[m_pend_lane];
        acc = cur_valid && exp_rdy;
        if (xf) begin
            m_pend = 0;
            if (m_pend_last) flush_due = cyc + 1;
        end
        if (acc) begin
            lane = blk_idx % N;
            exp_q[lane].push_back(cur_sym);
            m_pend = 1; m_pend_lane = lane; m_pend_sym = cur_sym; m_pend_last = cur_last;
            blk_idx++;
            m_count = m_arm ? CW'(1) : ((m_count == '1) ? m_count : m_count + CW'(1));
            m_arm = 0;
            if (cur_last) m_run = 0;
            cur_valid = 0; blk_left--; sym_seq++; accepted_total++;
        end
        if (cyc == flush_due) begin
            waiting = 1; flush_cyc = cyc; seen = '0;
        end
        if (waiting) begin
            seen |= lane_flush_done;
            if (&seen) begin
                done_due = (cyc + 1 > flush_cyc + 2) ? cyc + 1 : flush_cyc + 2;
                waiting = 0;
            end
        end
        if (cyc == done_due) begin
            m_run = 1; blk_idx = 0; m_arm = 1; blocks_done++;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1; s_valid = 0; s_last = 0; lane_flush_done = '0; lane_ready = '1;
        #1;
        check("s_ready_during_reset", s_ready, 0);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        rst = 0;
        model_reset();
    endtask

    task automatic start_block(input int len);
        blk_start_count = blocks_done;
        blk_left = len;
    endtask

    task automatic finish_block(input int budget);
        int n = 0;
        while (blocks_done == blk_start_count && n < budget) begin
            tick();
            n++;
        end
        check("block_completes_in_budget", blocks_done, blk_start_count + 1);
    endtask

    task automatic clear_recv();
        for (int k = 0; k < N; k++) recv_cnt[k] = 0;
    endtask

    initial begin
        int p0, a0, n, soak_blocks, soak_target;
        cyc = 0; blocks_done = 0; sym_seq = 0; accepted_total = 0;
        last_xfer_cyc = -1; dut_flush_cyc = -1; dut_done_cyc = -1; dut_done_pulses = 0;
        v_pct = 100; r_pct = 100; rdy_force_lo = '0; rand_sym = 0; rand_dly = 0;
        for (int k = 0; k < N; k++) dly[k] = 1;
        s_symbol = '0;
        clear_recv();
        model_reset();

        // reset state
        do_reset();
        tick();
        check("reset_sym_count", sym_count, 0);
        check("reset_lane_valid", lane_valid, 0);

        // basic round robin: symbols 0..9
        clear_recv();
        sym_seq = 0;
        p0 = dut_done_pulses;
        start_block(10);
        finish_block(200);
        check("basic_lane0_cnt", recv_cnt[0], 3);
        check("basic_lane1_cnt", recv_cnt[1], 3);
        check("basic_lane2_cnt", recv_cnt[2], 2);
        check("basic_lane3_cnt", recv_cnt[3], 2);
        check("basic_flush_after_last_xfer", dut_flush_cyc - last_xfer_cyc, 1);
        check("basic_sym_count", sym_count, 10);
        check("basic_done_pulses", dut_done_pulses - p0, 1);

        // stall on lane 1 for 20 cycles
        clear_recv();
        rdy_force_lo = 4'b0010;
        start_block(12);
        for (int i = 0; i < 20; i++) tick();
        check("stall_s_ready_low", s_ready, 0);
        check("stall_lane0_cnt", recv_cnt[0], 1);
        check("stall_lane2_idle", recv_cnt[2], 0);
        check("stall_lane3_idle", recv_cnt[3], 0);
        rdy_force_lo = '0;
        finish_block(200);
        for (int k = 0; k < N; k++) check($sformatf("stall_lane%0d_total", k), recv_cnt[k], 3);
        check("stall_sym_count", sym_count, 12);

        // staggered flush completion, with a stray done pulse in RUN first
        extra_done = '1;
        tick();
        extra_done = '0;
        dly[0] = 1; dly[1] = 5; dly[2] = 5; dly[3] = 12;
        p0 = dut_done_pulses;
        start_block(8);
        finish_block(300);
        check("stagger_done_after_flush", dut_done_cyc - dut_flush_cyc, 13);
        check("stagger_done_pulses", dut_done_pulses - p0, 1);
        for (int k = 0; k < N; k++) dly[k] = 0;

        // back-to-back single-symbol blocks
        p0 = dut_done_pulses;
        for (int b = 0; b < 3; b++) begin
            clear_recv();
            start_block(1);
            finish_block(50);
            check("single_goes_to_lane0", recv_cnt[0], 1);
            check("single_sym_count", sym_count, 1);
        end
        check("single_done_pulses", dut_done_pulses - p0, 3);
        for (int k = 0; k < N; k++) dly[k] = 1;

        // reset mid-block with the output register occupied
        a0 = accepted_total;
        n = 0;
        start_block(20);
        while (accepted_total - a0 < 5 && n < 100) begin
            tick();
            n++;
        end
        check("midrst_accepted", accepted_total - a0, 5);
        rdy_force_lo = '1;
        tick();
        check("midrst_reg_occupied", |lane_valid, 1);
        rdy_force_lo = '0;
        do_reset();
        for (int i = 0; i < 5; i++) tick();
        check("midrst_sym_count", sym_count, 0);
        clear_recv();
        start_block(6);
        finish_block(200);
        check("midrst_lane0_cnt", recv_cnt[0], 2);
        check("midrst_lane3_cnt", recv_cnt[3], 1);
        check("midrst_sym_count_after", sym_count, 6);

        // random soak
        rand_sym = 1; rand_dly = 1; v_pct = 80; r_pct = 85;
        soak_target = 20000;
        a0 = accepted_total;
        p0 = dut_done_pulses;
        soak_blocks = 0;
        while (accepted_total - a0 < soak_target && failures < 20) begin
            start_block(int'($urandom_range(1, 500)));
            finish_block(5000);
            soak_blocks++;
        end
        check("soak_done_per_last", dut_done_pulses - p0, soak_blocks);
        for (int k = 0; k < N; k++) check($sformatf("soak_lane%0d_drained", k), exp_q[k].size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
